// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler
// --------------------
// Shares one 12-bit SPI DAC serializer between NUM_REQ value producers.
// A round-robin arbiter picks a pending request, latches its code, pulses
// dac_start for one frame, then waits for dac_done (or a timeout) and keeps
// the serializer idle for GAP_CYCLES so chip-select stays deasserted.
//
// Ports (clk12MHz domain):
//   clk12MHz     system clock
//   rst          asynchronous, active-low reset
//   req_valid    per-requester request, held with stable data until acked
//   req_data     requester i code in bits [12*i+11:12*i]
//   req_ack      one-hot, one-cycle pulse: request accepted
//   dac_start    one-cycle pulse launching a serializer frame
//   dac_value    code for the serializer, stable from dac_start to next grant
//   dac_done     one-cycle pulse from serializer: frame finished
//   active_id    index of the last granted requester
//   busy         high in every state except IDLE
//   timeout_err  sticky frame-timeout flag, cleared only by reset
//   frame_count  completed frames, wraps silently
module dac_update_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk12MHz,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [12*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic                    dac_start,
    output logic [11:0]             dac_value,
    input  logic                    dac_done,
    output logic [2:0]              active_id,
    output logic                    busy,
    output logic                    timeout_err,
    output logic [15:0]             frame_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
    localparam logic [2:0]  ID_RESET     = 3'(NUM_REQ - 1);

    // Round-robin pick: first set bit searching upward from last+1, wrapping.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                           input logic [2:0] last);
        logic [NUM_REQ-1:0] sh;
        logic               found;
        int unsigned        cand;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            sh   = v >> cand;
            if (!found && sh[0]) begin
                rr_pick = 3'(cand);
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    state_t              state_r, state_s;
    logic [15:0]         timer_r, timer_s;
    logic [15:0]         gap_cnt_r, gap_cnt_s;
    logic [NUM_REQ-1:0]  req_ack_r, req_ack_s;
    logic                dac_start_r, dac_start_s;
    logic [11:0]         dac_value_r, dac_value_s;
    logic [2:0]          active_id_r, active_id_s;
    logic                busy_r, busy_s;
    logic                timeout_err_r, timeout_err_s;
    logic [15:0]         frame_count_r, frame_count_s;
    logic [2:0]          win_s;

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        state_s       = state_r;
        timer_s       = timer_r;
        gap_cnt_s     = gap_cnt_r;
        req_ack_s     = {NUM_REQ{1'b0}};
        dac_start_s   = 1'b0;
        dac_value_s   = dac_value_r;
        active_id_s   = active_id_r;
        timeout_err_s = timeout_err_r;
        frame_count_s = frame_count_r;
        win_s         = rr_pick(req_valid, active_id_r);

        case (state_r)
            IDLE: begin
                if (|req_valid) begin
                    // ack and start are registered here so both appear in START
                    dac_value_s = req_data[12*int'(win_s) +: 12];
                    active_id_s = win_s;
                    req_ack_s   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
                    dac_start_s = 1'b1;
                    state_s     = START;
                end else begin
                    state_s     = IDLE;
                end
            end
            START: begin
                timer_s = 16'd0;
                state_s = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done has priority over a timeout landing on the same edge
                if (dac_done) begin
                    frame_count_s = frame_count_r + 16'd1;
                    gap_cnt_s     = 16'd0;
                    state_s       = GAP;
                end else if (timer_r == TIMEOUT_LAST) begin
                    timeout_err_s = 1'b1;
                    gap_cnt_s     = 16'd0;
                    state_s       = GAP;
                end else begin
                    timer_s       = timer_r + 16'd1;
                end
            end
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s   = IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk12MHz or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            timer_r       <= 16'd0;
            gap_cnt_r     <= 16'd0;
            req_ack_r     <= {NUM_REQ{1'b0}};
            dac_start_r   <= 1'b0;
            dac_value_r   <= 12'd0;
            active_id_r   <= ID_RESET;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            gap_cnt_r     <= gap_cnt_s;
            req_ack_r     <= req_ack_s;
            dac_start_r   <= dac_start_s;
            dac_value_r   <= dac_value_s;
            active_id_r   <= active_id_s;
            busy_r        <= busy_s;
            timeout_err_r <= timeout_err_s;
            frame_count_r <= frame_count_s;
        end
    end

    assign req_ack     = req_ack_r;
    assign dac_start   = dac_start_r;
    assign dac_value   = dac_value_r;
    assign active_id   = active_id_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed, scoreboard-based bench for dac_update_scheduler
// (NUM_REQ=4, GAP_CYCLES=16, TIMEOUT_CYCLES=100).
module tb_dac_update_scheduler;

    localparam int NR  = 4;
    localparam int GAP = 16;
    localparam int TO  = 100;

    logic              clk12MHz;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [12*NR-1:0]  req_data;
    logic [NR-1:0]     req_ack;
    logic              dac_start;
    logic [11:0]       dac_value;
    logic              dac_done;
    logic [2:0]        active_id;
    logic              busy;
    logic              timeout_err;
    logic [15:0]       frame_count;

    dac_update_scheduler #(
        .NUM_REQ(NR), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk12MHz(clk12MHz), .rst(rst), .req_valid(req_valid),
        .req_data(req_data), .req_ack(req_ack), .dac_start(dac_start),
        .dac_value(dac_value), .dac_done(dac_done), .active_id(active_id),
        .busy(busy), .timeout_err(timeout_err), .frame_count(frame_count)
    );

    typedef struct {
        logic [2:0]  id;
        logic [11:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    initial begin
        clk12MHz = 1'b0;
        forever #5 clk12MHz = ~clk12MHz;
    end

    always @(posedge clk12MHz) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] id, input logic [11:0] val);
        exp_t e;
        e.id  = id;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic set_data(input int i, input logic [11:0] val);
        req_data[12*i +: 12] = val;
    endtask

    // Wait for a dac_start, compare against the scoreboard head, check pulse width.
    task automatic wait_start(input int budget, output int t);
        int   n;
        exp_t e;
        logic [NR-1:0] one;
        n = 0;
        @(negedge clk12MHz);
        while (!dac_start && n < budget) begin
            @(negedge clk12MHz);
            n++;
        end
        t = cyc;
        chk("start_seen", {31'd0, dac_start}, 32'd1);
        chk("sb_depth", {31'd0, (sb_q.size() > 0)}, 32'd1);
        if (dac_start && sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            one = 4'b0001 << e.id;
            chk("ack", {28'd0, req_ack}, {28'd0, one});
            chk("dac_value", {20'd0, dac_value}, {20'd0, e.val});
            chk("active_id", {29'd0, active_id}, {29'd0, e.id});
            chk("busy_start", {31'd0, busy}, 32'd1);
            @(negedge clk12MHz);
            chk("start_pulse", {31'd0, dac_start}, 32'd0);
            chk("ack_pulse", {28'd0, req_ack}, 32'd0);
        end
    endtask

    task automatic goto(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 2000) begin
            @(negedge clk12MHz);
            n++;
        end
        chk("goto", cyc, target);
    endtask

    task automatic pulse_done();
        dac_done = 1'b1;
        @(negedge clk12MHz);
        dac_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk12MHz);
        rst = 1'b1;
        @(negedge clk12MHz);
    endtask

    initial begin
        int s, prev, d;
        logic [2:0] order [6];
        order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd2;
        order[3] = 3'd3; order[4] = 3'd0; order[5] = 3'd1;

        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        dac_done  = 1'b0;
        repeat (3) @(negedge clk12MHz);

        // reset state
        chk("rst_ack", {28'd0, req_ack}, 32'd0);
        chk("rst_start", {31'd0, dac_start}, 32'd0);
        chk("rst_value", {20'd0, dac_value}, 32'd0);
        chk("rst_id", {29'd0, active_id}, 32'd3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_count", {16'd0, frame_count}, 32'd0);
        rst = 1'b1;
        @(negedge clk12MHz);

        // single request, latency one cycle
        set_data(2, 12'hABC);
        req_valid = 4'b0100;
        push_exp(3'd2, 12'hABC);
        prev = cyc;
        wait_start(5, s);
        chk("latency", s - prev, 1);
        req_valid = '0;
        goto(s + 40);
        d = cyc;
        pulse_done();
        chk("count1", {16'd0, frame_count}, 32'd1);
        goto(d + GAP);
        chk("busy_gap_end", {31'd0, busy}, 32'd1);
        @(negedge clk12MHz);
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // round-robin with all requesters continuously valid
        do_reset();
        for (int i = 0; i < NR; i++) set_data(i, 12'(12'h100 + 12'(i)));
        for (int k = 0; k < 6; k++) push_exp(order[k], 12'(12'h100 + 12'(order[k])));
        req_valid = 4'b1111;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_start(60, s);
            if (k > 0) chk("rr_spacing", s - prev, 10 + GAP + 2);
            prev = s;
            goto(s + 10);
            pulse_done();
            if (k == 5) req_valid = '0;
        end
        chk("rr_count", {16'd0, frame_count}, 32'd6);

        // dac_done coincident with the timeout edge: done wins
        goto(prev + 10 + GAP + 1);
        set_data(2, 12'h777);
        req_valid = 4'b0100;
        push_exp(3'd2, 12'h777);
        wait_start(5, s);
        req_valid = '0;
        goto(s + TO);
        d = cyc;
        pulse_done();
        chk("corner_err", {31'd0, timeout_err}, 32'd0);
        chk("corner_count", {16'd0, frame_count}, 32'd7);
        // dac_done during GAP is ignored
        goto(d + 5);
        pulse_done();
        chk("gap_done_count", {16'd0, frame_count}, 32'd7);
        goto(d + GAP);
        chk("gap_done_busy", {31'd0, busy}, 32'd1);
        @(negedge clk12MHz);
        chk("gap_done_idle", {31'd0, busy}, 32'd0);
        // dac_done in IDLE is ignored
        pulse_done();
        chk("idle_done_count", {16'd0, frame_count}, 32'd7);
        chk("idle_done_busy", {31'd0, busy}, 32'd0);
        chk("idle_done_start", {31'd0, dac_start}, 32'd0);

        // timeout: exactly TO cycles in WAIT_DONE
        set_data(3, 12'h5A5);
        req_valid = 4'b1000;
        push_exp(3'd3, 12'h5A5);
        wait_start(5, s);
        req_valid = '0;
        goto(s + TO);
        chk("to_busy_last", {31'd0, busy}, 32'd1);
        chk("to_err_before", {31'd0, timeout_err}, 32'd0);
        @(negedge clk12MHz);
        chk("to_err_set", {31'd0, timeout_err}, 32'd1);
        chk("to_count", {16'd0, frame_count}, 32'd7);
        goto(s + TO + GAP);
        chk("to_gap_busy", {31'd0, busy}, 32'd1);
        @(negedge clk12MHz);
        chk("to_idle", {31'd0, busy}, 32'd0);
        // next request still served, error stays sticky
        set_data(0, 12'h123);
        req_valid = 4'b0001;
        push_exp(3'd0, 12'h123);
        wait_start(5, s);
        req_valid = '0;
        goto(s + 5);
        pulse_done();
        chk("post_to_count", {16'd0, frame_count}, 32'd8);
        chk("err_sticky", {31'd0, timeout_err}, 32'd1);

        // reset in the middle of a frame
        goto(s + 5 + GAP + 1);
        set_data(1, 12'h321);
        req_valid = 4'b0010;
        push_exp(3'd1, 12'h321);
        wait_start(5, s);
        goto(s + 5);
        set_data(0, 12'h0F0);
        req_valid = 4'b0001;
        #2 rst = 1'b0;
        #1;
        chk("mid_ack", {28'd0, req_ack}, 32'd0);
        chk("mid_start", {31'd0, dac_start}, 32'd0);
        chk("mid_value", {20'd0, dac_value}, 32'd0);
        chk("mid_id", {29'd0, active_id}, 32'd3);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_err", {31'd0, timeout_err}, 32'd0);
        chk("mid_count", {16'd0, frame_count}, 32'd0);
        @(negedge clk12MHz);
        rst = 1'b1;
        push_exp(3'd0, 12'h0F0);
        wait_start(5, s);
        req_valid = '0;
        goto(s + 3);
        pulse_done();
        chk("post_rst_count", {16'd0, frame_count}, 32'd1);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
